// File: rtl/div_unit_pkg.sv
// Shared types for the iterative RV32M divider: operation codes, FSM states,
// register ids and a sign-aware absolute-value helper.
package div_unit_pkg;

  localparam int XLEN = 32;

  typedef logic [4:0]      regId_t;
  typedef logic [XLEN-1:0] uint32;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } divOp_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } divState_t;

  function automatic logic is_signed_op(input divOp_t op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_rem_op(input divOp_t op);
    return (op == REM) || (op == REMU);
  endfunction

  // 33-bit negate so that |0x80000000| comes out as unsigned 0x80000000.
  function automatic uint32 abs_val(input uint32 v, input logic sgn);
    logic [32:0] ext;
    ext = {sgn & v[31], v};
    if (sgn && v[31]) begin
      ext = 33'd0 - ext;
    end
    return ext[31:0];
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request / write-back bundle between execute, the divider and the register-file
// write port.
interface div_unit_if;
  import div_unit_pkg::*;

  logic   start;
  divOp_t op;
  uint32  dividend;
  uint32  divisor;
  regId_t rd;
  logic   flush;
  logic   busy;
  logic   wb_en;
  regId_t wb_reg;
  uint32  wb_data;

  modport master (
    output start, op, dividend, divisor, rd, flush,
    input  busy, wb_en, wb_reg, wb_data
  );

  modport slave (
    input  start, op, dividend, divisor, rd, flush,
    output busy, wb_en, wb_reg, wb_data
  );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step (
  input  logic [32:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] divisor_i,
  output logic [32:0] rem_o,
  output logic [31:0] quo_o
);

  logic [33:0] rem_sh;
  logic [32:0] diff;
  logic        fits;

  assign rem_sh = {rem_i, quo_i[31]};
  assign fits   = (rem_sh >= {2'b00, divisor_i});
  // When the divisor fits, the difference is below the divisor, so 33 bits suffice.
  assign diff   = rem_sh[32:0] - {1'b0, divisor_i};
  assign rem_o  = fits ? diff : rem_sh[32:0];
  assign quo_o  = {quo_i[30:0], fits};

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider: latches rs1/rs2 on start, runs BITS_PER_CYCLE restoring
// steps per cycle, then issues a single register-file write-back.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  div_unit_if.slave  bus
);

  localparam int N     = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

  divState_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [32:0]      rem_q;
  uint32            quo_q;
  uint32            divisor_q;
  divOp_t           op_q;
  regId_t           rd_q;
  logic             qneg_q;
  logic             rneg_q;
  regId_t           wb_reg_q;
  uint32            wb_data_q;

  logic        req_signed;
  logic        div_zero;
  logic        sp_ovf;
  uint32       special_res;
  logic [32:0] rem_fin;
  uint32       quo_fin;
  uint32       quo_fix;
  uint32       rem_fix;
  uint32       calc_res;

  assign req_signed = is_signed_op(bus.op);
  assign div_zero   = (bus.divisor == 32'd0);
  assign sp_ovf     = req_signed && (bus.dividend == 32'h8000_0000) &&
                      (bus.divisor == 32'hFFFF_FFFF);

  always_comb begin
    special_res = 32'd0;
    if (is_rem_op(bus.op)) begin
      special_res = div_zero ? bus.dividend : 32'd0;
    end else begin
      special_res = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
    end
  end

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    logic [32:0] rem_in;
    logic [32:0] rem_out;
    uint32       quo_in;
    uint32       quo_out;
    if (g == 0) begin : g_first
      assign rem_in = rem_q;
      assign quo_in = quo_q;
    end else begin : g_next
      assign rem_in = g_step[g-1].rem_out;
      assign quo_in = g_step[g-1].quo_out;
    end
    div_step u_step (
      .rem_i     (rem_in),
      .quo_i     (quo_in),
      .divisor_i (divisor_q),
      .rem_o     (rem_out),
      .quo_o     (quo_out)
    );
  end

  assign rem_fin  = g_step[BITS_PER_CYCLE-1].rem_out;
  assign quo_fin  = g_step[BITS_PER_CYCLE-1].quo_out;
  assign quo_fix  = qneg_q ? (32'd0 - quo_fin) : quo_fin;
  assign rem_fix  = rneg_q ? (32'd0 - rem_fin[31:0]) : rem_fin[31:0];
  assign calc_res = is_rem_op(op_q) ? rem_fix : quo_fix;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      op_q      <= DIV;
      rd_q      <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      wb_reg_q  <= '0;
      wb_data_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.flush || !bus.start) begin
            state_q <= IDLE;
          end else begin
            op_q      <= bus.op;
            rd_q      <= bus.rd;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= abs_val(bus.dividend, req_signed);
            divisor_q <= abs_val(bus.divisor, req_signed);
            qneg_q    <= req_signed & (bus.dividend[31] ^ bus.divisor[31]);
            rneg_q    <= req_signed & bus.dividend[31];
            // Divide-by-zero and signed overflow bypass the iteration entirely.
            if (div_zero || sp_ovf) begin
              state_q   <= DONE;
              wb_reg_q  <= bus.rd;
              wb_data_q <= special_res;
            end else begin
              state_q   <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.flush) begin
            state_q <= IDLE;
          end else begin
            rem_q <= rem_fin;
            quo_q <= quo_fin;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
              state_q   <= DONE;
              wb_reg_q  <= rd_q;
              wb_data_q <= calc_res;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy    = (state_q == CALC);
  // Combinational on flush so a kill in the DONE cycle still blocks the write.
  assign bus.wb_en   = (state_q == DONE) && (rd_q != 5'd0) && !bus.flush;
  assign bus.wb_reg  = wb_reg_q;
  assign bus.wb_data = wb_data_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M cases plus randomized operations
// checked against an arithmetic reference model.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int BPC = 1;
  localparam int LAT = 32 / BPC + 1;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  div_unit_if bus ();

  div_unit #(.BITS_PER_CYCLE(BPC)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic        sgn;
    logic [31:0] q;
    logic [31:0] r;
    int          sa;
    int          sb;
    sgn = (op == 2'b00) || (op == 2'b10);
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (sgn) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic logic is_special(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    return (b == 32'd0) ||
           (((op == 2'b00) || (op == 2'b10)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.op       = divOp_t'(op);
    bus.dividend = a;
    bus.divisor  = b;
    bus.rd       = rd;
  endtask

  // Observes ncyc cycles after acceptance; optionally pulses a second start at poke_c.
  task automatic run_window(input int ncyc, input int poke_c, output int wb_c,
                            output int wb_n, output int busy_n,
                            output logic [4:0] r, output logic [31:0] d);
    wb_c = -1; wb_n = 0; busy_n = 0; r = '0; d = '0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.wb_en) begin
        wb_n++;
        if (wb_c < 0) begin
          wb_c = c; r = bus.wb_reg; d = bus.wb_data;
        end
      end
      bus.start = (c == poke_c);
      if (c == poke_c) begin
        bus.op = DIVU; bus.dividend = 32'd50; bus.divisor = 32'd5; bus.rd = 5'd7;
      end
      bus.flush = 1'b0;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks += 4;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    if (bus.wb_en !== 1'b0) begin n_fail++; $display("FAIL reset_wb_en got %b want 0", bus.wb_en); end
    if (bus.wb_reg !== 5'd0) begin n_fail++; $display("FAIL reset_wb_reg got %0d want 0", bus.wb_reg); end
    if (bus.wb_data !== 32'd0) begin n_fail++; $display("FAIL reset_wb_data got %h want 0", bus.wb_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned;
    int wc, wn, bn; logic [4:0] r; logic [31:0] d;
    issue(2'b01, 32'd100, 32'd7, 5'd5);
    run_window(LAT + 2, 0, wc, wn, bn, r, d);
    n_checks += 6;
    if (wc !== LAT) begin n_fail++; $display("FAIL divu_latency got %0d want %0d", wc, LAT); end
    if (wn !== 1) begin n_fail++; $display("FAIL divu_wb_pulses got %0d want 1", wn); end
    if (bn !== LAT - 1) begin n_fail++; $display("FAIL divu_busy_cycles got %0d want %0d", bn, LAT - 1); end
    if (r !== 5'd5) begin n_fail++; $display("FAIL divu_wb_reg got %0d want 5", r); end
    if (d !== 32'd14) begin n_fail++; $display("FAIL divu_data got %0d want 14", d); end
    if (bus.wb_data !== 32'd14) begin n_fail++; $display("FAIL divu_hold got %0d want 14", bus.wb_data); end
    issue(2'b11, 32'd100, 32'd7, 5'd5);
    run_window(LAT + 2, 0, wc, wn, bn, r, d);
    n_checks++;
    if (d !== 32'd2) begin n_fail++; $display("FAIL remu_data got %0d want 2", d); end
  endtask

  task automatic test_signed;
    logic [1:0]  ops [3] = '{2'b00, 2'b10, 2'b10};
    logic [31:0] as  [3] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7};
    logic [31:0] bs  [3] = '{32'd2, 32'd2, 32'hFFFF_FFFE};
    logic [31:0] ex  [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1};
    int wc, wn, bn; logic [4:0] r; logic [31:0] d;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], as[i], bs[i], 5'd9);
      run_window(LAT + 2, 0, wc, wn, bn, r, d);
      n_checks += 2;
      if (d !== ex[i]) begin n_fail++; $display("FAIL signed_%0d got %h want %h", i, d, ex[i]); end
      if (wc !== LAT) begin n_fail++; $display("FAIL signed_lat_%0d got %0d want %0d", i, wc, LAT); end
    end
  endtask

  task automatic test_special;
    logic [1:0]  ops [4] = '{2'b01, 2'b10, 2'b00, 2'b11};
    logic [31:0] as  [4] = '{32'd1234, 32'h8000_0000, 32'h8000_0000, 32'hDEAD_BEEF};
    logic [31:0] bs  [4] = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] ex  [4] = '{32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'hDEAD_BEEF};
    int wc, wn, bn; logic [4:0] r; logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i], 5'd3);
      run_window(4, 0, wc, wn, bn, r, d);
      n_checks += 3;
      if (d !== ex[i]) begin n_fail++; $display("FAIL special_%0d got %h want %h", i, d, ex[i]); end
      if (wc !== 1) begin n_fail++; $display("FAIL special_lat_%0d got %0d want 1", i, wc); end
      if (bn !== 0) begin n_fail++; $display("FAIL special_busy_%0d got %0d want 0", i, bn); end
    end
  endtask

  task automatic test_flush;
    int wn, wc, bn; logic [4:0] r; logic [31:0] d;
    issue(2'b01, 32'd100, 32'd7, 5'd5);
    wn = 0;
    for (int c = 1; c <= LAT + 5; c++) begin
      @(negedge clk);
      if (bus.wb_en) wn++;
      if (c == 11) begin
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %b want 0", bus.busy); end
      end
      bus.start = 1'b0;
      bus.flush = (c == 10);
    end
    n_checks++;
    if (wn !== 0) begin n_fail++; $display("FAIL flush_no_wb got %0d want 0", wn); end
    issue(2'b01, 32'd9, 32'd3, 5'd4);
    run_window(LAT + 2, 0, wc, wn, bn, r, d);
    n_checks += 2;
    if (d !== 32'd3) begin n_fail++; $display("FAIL after_flush_data got %0d want 3", d); end
    if (wc !== LAT) begin n_fail++; $display("FAIL after_flush_lat got %0d want %0d", wc, LAT); end
    issue(2'b01, 32'd9, 32'd3, 5'd4);
    bus.flush = 1'b1;
    run_window(LAT + 2, 0, wc, wn, bn, r, d);
    n_checks += 2;
    if (wn !== 0) begin n_fail++; $display("FAIL flush_start_wb got %0d want 0", wn); end
    if (bn !== 0) begin n_fail++; $display("FAIL flush_start_busy got %0d want 0", bn); end
  endtask

  task automatic test_rd0_and_busy_start;
    int wc, wn, bn; logic [4:0] r; logic [31:0] d;
    issue(2'b01, 32'd8, 32'd2, 5'd0);
    run_window(LAT + 12, 5, wc, wn, bn, r, d);
    n_checks += 2;
    if (wn !== 0) begin n_fail++; $display("FAIL rd0_wb got %0d want 0", wn); end
    if (bn !== LAT - 1) begin n_fail++; $display("FAIL rd0_busy got %0d want %0d", bn, LAT - 1); end
    issue(2'b01, 32'd100, 32'd7, 5'd5);
    run_window(LAT + 12, 5, wc, wn, bn, r, d);
    n_checks += 2;
    if (wn !== 1) begin n_fail++; $display("FAIL ignore_start_pulses got %0d want 1", wn); end
    if (d !== 32'd14) begin n_fail++; $display("FAIL ignore_start_data got %0d want 14", d); end
  endtask

  task automatic test_random;
    logic [1:0] op; logic [31:0] a, b; logic [4:0] rd;
    int wc, wn, bn, sel; logic [4:0] r; logic [31:0] d;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
      rd = 5'($urandom_range(1, 31)); sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (sel == 2) b = $urandom_range(1, 15);
      if (sel == 3) b = 32'd0 - $urandom_range(1, 15);
      issue(op, a, b, rd);
      run_window(LAT + 1, 0, wc, wn, bn, r, d);
      n_checks += 3;
      if (d !== model(op, a, b)) begin n_fail++; $display("FAIL rand_%0d op%0d %h/%h got %h want %h", i, op, a, b, d, model(op, a, b)); end
      if (wc !== (is_special(op, a, b) ? 1 : LAT)) begin n_fail++; $display("FAIL rand_lat_%0d got %0d", i, wc); end
      if (r !== rd) begin n_fail++; $display("FAIL rand_reg_%0d got %0d want %0d", i, r, rd); end
    end
  endtask

  task automatic test_back_to_back;
    int wcs[$]; logic [31:0] wds[$]; int wn;
    issue(2'b01, 32'd100, 32'd7, 5'd5);
    for (int c = 1; c <= 2 * LAT + 4; c++) begin
      @(negedge clk);
      if (bus.wb_en) begin wcs.push_back(c); wds.push_back(bus.wb_data); end
      bus.start = (c == LAT);
      if (c == LAT) begin
        bus.op = DIVU; bus.dividend = 32'd200; bus.divisor = 32'd9; bus.rd = 5'd6;
      end
    end
    n_checks += 3;
    if (wcs.size() !== 2) begin
      n_fail++; $display("FAIL b2b_count got %0d want 2", wcs.size());
    end else begin
      if (wcs[1] - wcs[0] !== LAT) begin n_fail++; $display("FAIL b2b_spacing got %0d want %0d", wcs[1] - wcs[0], LAT); end
      if (wds[1] !== 32'd22) begin n_fail++; $display("FAIL b2b_data got %0d want 22", wds[1]); end
    end
    issue(2'b01, 32'd100, 32'd7, 5'd5);
    wn = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_checks += 4;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", bus.busy); end
    if (bus.wb_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wb_en got %b want 0", bus.wb_en); end
    if (bus.wb_reg !== 5'd0) begin n_fail++; $display("FAIL rst_mid_wb_reg got %0d want 0", bus.wb_reg); end
    if (bus.wb_data !== 32'd0) begin n_fail++; $display("FAIL rst_mid_wb_data got %h want 0", bus.wb_data); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < LAT + 4; c++) begin
      @(negedge clk);
      if (bus.wb_en) wn++;
    end
    n_checks++;
    if (wn !== 0) begin n_fail++; $display("FAIL rst_mid_no_wb got %0d want 0", wn); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = DIV;
    bus.dividend = '0; bus.divisor = '0; bus.rd = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_flush();
    test_rd0_and_busy_start();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
